result_collector: RTL

- Parametrised successor to the single-batch result store. Sits between the classifier cores and the result-queue write port.
- Per batch: captures the pass/fail vector from all cores in one handshake, then writes only the passing entries to the queue, one per cycle.
- Uses a lowest-set-bit scan, so a batch drains in N cycles for N hits, not CORES cycles. Also emits an end-of-stream word on exit.

---
 rtl/result_collector_pkg.sv | 40 ++++
 rtl/result_collector_lowest_set_idx.sv | 30 +++
 rtl/result_collector.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/result_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkg_resultCollector
//  Description : Shared types and helpers for the result collector: the state
//                encoding, the core-index width helper and the queue-word
//                packing function.
//  Revision    : 1.0 - initial release
// ============================================================================
package pkg_resultCollector;

    // Collector states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        S_Idle    = 2'd0,
        S_Capture = 2'd1,
        S_Drain   = 2'd2,
        S_Exit    = 2'd3
    } STATES_t;

    // Widest queue word the packing helper can build
    localparam int c_PACK_MAX_W = 128;

    // Width of a core index, never narrower than one bit
    function automatic int core_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Packs {x, y, scale} LSB-aligned; the caller truncates to its word width.
    // Inputs are expected to be zero-extended already.
    function automatic logic [c_PACK_MAX_W-1:0] pack_word(
        input logic [c_PACK_MAX_W-1:0] x,
        input logic [c_PACK_MAX_W-1:0] y,
        input logic [c_PACK_MAX_W-1:0] scale,
        input int                      y_w,
        input int                      scale_w
    );
        return (x << (y_w + scale_w)) | (y << scale_w) | scale;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_collector_lowest_set_idx.sv
`default_nettype none
// ============================================================================
//  Module      : lowest_set_idx
//  Description : Combinational priority encoder returning the index of the
//                lowest set bit of a vector, plus an any-bit-set flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module lowest_set_idx #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last one to win
    always_comb begin
        index = '0;
        any   = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = IDX_W'(i);
                any   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : result_collector
//  Description : Captures one pass/fail vector per batch from all classifier
//                cores, then writes one queue word per passing core (lowest
//                index first, one per non-full cycle). A start with exit set
//                writes a single end-of-stream word instead.
//                Optional macro RESULT_COLLECTOR_HITCOUNT_EN: the end-of-stream
//                word carries a saturating count of hits written since the
//                previous end-of-stream word; otherwise it is all ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_collector
    import pkg_resultCollector::*;
#(
    parameter int CORES   = 8,
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int SCALE_W = 5,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ctl_start,
    input  logic               ctl_exit,
    input  logic [X_W-1:0]     ctl_x,
    input  logic [Y_W-1:0]     ctl_y,
    input  logic [SCALE_W-1:0] ctl_scale,
    output logic               ctl_ready,
    input  logic [CORES-1:0]   core_valid,
    input  logic [CORES-1:0]   core_passfail,
    output logic               core_taken,
    input  logic               q_full,
    output logic               q_we,
    output logic [DATA_W-1:0]  q_data
);

    localparam int c_CORE_IDX_W = core_idx_w(CORES);

    // Reject configurations the word packing cannot represent
    generate
        if (DATA_W < X_W + Y_W + SCALE_W || DATA_W > c_PACK_MAX_W ||
            CORES < 1 || CORES > 64) begin : g_param_check
            $error("result_collector: illegal CORES/DATA_W/field-width combination");
        end
    endgenerate

    STATES_t                 r_state;
    logic [CORES-1:0]        r_mask;
    logic [X_W-1:0]          r_x;
    logic [Y_W-1:0]          r_y;
    logic [SCALE_W-1:0]      r_scale;
    logic                    r_q_we;
    logic [DATA_W-1:0]       r_q_data;

    logic [c_CORE_IDX_W-1:0] w_idx;
    logic                    w_any;
    logic                    w_all_valid;
    logic [CORES-1:0]        w_onehot;
    logic [CORES-1:0]        w_mask_next;
    logic [X_W+c_CORE_IDX_W-1:0] w_x_wide;
    logic [X_W-1:0]          w_x_sum;
    logic [DATA_W-1:0]       w_hit_word;
    logic [DATA_W-1:0]       w_exit_word;

    lowest_set_idx #(
        .WIDTH (CORES),
        .IDX_W (c_CORE_IDX_W)
    ) u_lsb (
        .vec   (r_mask),
        .index (w_idx),
        .any   (w_any)
    );

    assign w_all_valid = &core_valid;
    assign w_onehot    = CORES'(1) << w_idx;
    assign w_mask_next = r_mask & ~w_onehot;

    // Core x plus lane index, wrapping at the x field width
    assign w_x_wide = {{c_CORE_IDX_W{1'b0}}, r_x} + {{X_W{1'b0}}, w_idx};
    assign w_x_sum  = w_x_wide[X_W-1:0];

    assign w_hit_word = DATA_W'(pack_word(c_PACK_MAX_W'(w_x_sum),
                                          c_PACK_MAX_W'(r_y),
                                          c_PACK_MAX_W'(r_scale),
                                          Y_W, SCALE_W));

`ifdef RESULT_COLLECTOR_HITCOUNT_EN
    logic [DATA_W-2:0] r_hit_cnt;

    // Count hits written since the last end-of-stream word, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_cnt <= '0;
        end else if (r_state == S_Exit && !q_full) begin
            r_hit_cnt <= '0;
        end else if (r_state == S_Drain && !q_full && w_any && r_hit_cnt != '1) begin
            r_hit_cnt <= r_hit_cnt + {{(DATA_W-2){1'b0}}, 1'b1};
        end
    end

    assign w_exit_word = {1'b1, r_hit_cnt};
`else
    assign w_exit_word = '1;
`endif

    // Batch sequencing: latch controls, capture the vector, drain hits, exit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_Idle;
            r_mask   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_scale  <= '0;
            r_q_we   <= 1'b0;
            r_q_data <= '0;
        end else begin
            r_q_we <= 1'b0;
            case (r_state)
                S_Idle: begin
                    if (ctl_start) begin
                        if (ctl_exit) begin
                            r_state <= S_Exit;
                        end else begin
                            r_x     <= ctl_x;
                            r_y     <= ctl_y;
                            r_scale <= ctl_scale;
                            r_state <= S_Capture;
                        end
                    end
                end
                S_Capture: begin
                    if (w_all_valid) begin
                        r_mask  <= core_passfail;
                        r_state <= (core_passfail == '0) ? S_Idle : S_Drain;
                    end
                end
                S_Drain: begin
                    if (!w_any) begin
                        r_state <= S_Idle;
                    end else if (!q_full) begin
                        r_q_we   <= 1'b1;
                        r_q_data <= w_hit_word;
                        r_mask   <= w_mask_next;
                        if (w_mask_next == '0) begin
                            r_state <= S_Idle;
                        end
                    end
                end
                S_Exit: begin
                    if (!q_full) begin
                        r_q_we   <= 1'b1;
                        r_q_data <= w_exit_word;
                        r_state  <= S_Idle;
                    end
                end
                default: r_state <= S_Idle;
            endcase
        end
    end

    assign ctl_ready  = (r_state == S_Idle);
    assign core_taken = (r_state == S_Capture) && w_all_valid;
    assign q_we       = r_q_we;
    assign q_data     = r_q_data;

endmodule
`default_nettype wire
